sobel_window_gen: RTL and testbench

Raster-to-window front end for the deterministic Sobel datapath. Accepts an 8-bit grayscale pixel stream in row-major order with a valid/ready handshake. Buffers two image lines and emits, for every interior pixel, the full 3x3 neighbourhood z1..z9 that the combinational Sobel 3x3 core consumes. Sits between the pixel source and the Sobel core; its output register is the pipeline stage in front of that core.

---
 rtl/sobel_pkg.sv | 19 +
 rtl/sobel_line_buffer.sv | 24 ++
 rtl/sobel_window_gen.sv | 132 +++++++++++++
 tb/tb_sobel_window_gen.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/sobel_pkg.sv
// Shared definitions for the Sobel front end: pixel width, default image size
// and the z1..z9 window index order used by the core and the software model.
package sobel_pkg;

    localparam int PIX_W     = 8;
    localparam int IMG_W_DEF = 64;
    localparam int IMG_H_DEF = 64;
    localparam int WIN_N     = 9;

    typedef logic [PIX_W-1:0] pix_t;

    // Row-major over the 3x3 neighbourhood: top row oldest line, left to right.
    typedef enum logic [3:0] {
        Z1 = 4'd0, Z2 = 4'd1, Z3 = 4'd2,
        Z4 = 4'd3, Z5 = 4'd4, Z6 = 4'd5,
        Z7 = 4'd6, Z8 = 4'd7, Z9 = 4'd8
    } win_idx_e;

endpackage

// File: rtl/sobel_line_buffer.sv
// One image line of pixels; combinational read and registered write at the
// same address, so a read in the write cycle returns the old contents.
module sobel_line_buffer
    import sobel_pkg::*;
#(
    parameter int DEPTH  = IMG_W_DEF,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  pix_t              wdata,
    output pix_t              rdata
);

    pix_t mem [DEPTH];

    assign rdata = mem[addr];

    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
    end

endmodule

// File: rtl/sobel_window_gen.sv
// Raster-to-window front end: two line buffers plus a 3x3 shift window,
// emitting one registered neighbourhood per interior pixel.
module sobel_window_gen
    import sobel_pkg::*;
#(
    parameter int IMG_W = IMG_W_DEF,
    parameter int IMG_H = IMG_H_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [PIX_W-1:0] in_pixel,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [PIX_W-1:0] z1,
    output logic [PIX_W-1:0] z2,
    output logic [PIX_W-1:0] z3,
    output logic [PIX_W-1:0] z4,
    output logic [PIX_W-1:0] z5,
    output logic [PIX_W-1:0] z6,
    output logic [PIX_W-1:0] z7,
    output logic [PIX_W-1:0] z8,
    output logic [PIX_W-1:0] z9,
    output logic             frame_done
);

    localparam int COL_W = $clog2(IMG_W);
    localparam int ROW_W = $clog2(IMG_H);

    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic             accept;
    logic             col_last;
    logic             row_last;
    logic             emit;
    pix_t             top_px;
    pix_t             mid_px;
    pix_t             top_sr [2];
    pix_t             mid_sr [2];
    pix_t             bot_sr [2];
    pix_t             z_win [WIN_N];
    logic             out_valid_q;
    logic             frame_done_q;

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;
    assign col_last = (col == COL_W'(IMG_W - 1));
    assign row_last = (row == ROW_W'(IMG_H - 1));
    assign emit     = accept && (row >= ROW_W'(2)) && (col >= COL_W'(2));

    // lb0 holds the previous line; lb1 receives what lb0 held (line before).
    sobel_line_buffer #(.DEPTH(IMG_W), .ADDR_W(COL_W)) u_lb0 (
        .clk   (clk),
        .we    (accept),
        .addr  (col),
        .wdata (in_pixel),
        .rdata (mid_px)
    );

    sobel_line_buffer #(.DEPTH(IMG_W), .ADDR_W(COL_W)) u_lb1 (
        .clk   (clk),
        .we    (accept),
        .addr  (col),
        .wdata (mid_px),
        .rdata (top_px)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col <= '0;
            row <= '0;
        end else if (accept) begin
            if (col_last) begin
                col <= '0;
                row <= row_last ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    // Two previous columns of the window; the current column comes straight
    // from the line-buffer reads and the incoming pixel.
    always_ff @(posedge clk) begin
        if (accept) begin
            top_sr[0] <= top_sr[1];
            top_sr[1] <= top_px;
            mid_sr[0] <= mid_sr[1];
            mid_sr[1] <= mid_px;
            bot_sr[0] <= bot_sr[1];
            bot_sr[1] <= in_pixel;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < WIN_N; i++) z_win[i] <= '0;
            out_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= accept && col_last && row_last;
            if (emit) begin
                z_win[Z1]   <= top_sr[0];
                z_win[Z2]   <= top_sr[1];
                z_win[Z3]   <= top_px;
                z_win[Z4]   <= mid_sr[0];
                z_win[Z5]   <= mid_sr[1];
                z_win[Z6]   <= mid_px;
                z_win[Z7]   <= bot_sr[0];
                z_win[Z8]   <= bot_sr[1];
                z_win[Z9]   <= in_pixel;
                out_valid_q <= 1'b1;
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign out_valid  = out_valid_q;
    assign frame_done = frame_done_q;
    assign z1 = z_win[Z1];
    assign z2 = z_win[Z2];
    assign z3 = z_win[Z3];
    assign z4 = z_win[Z4];
    assign z5 = z_win[Z5];
    assign z6 = z_win[Z6];
    assign z7 = z_win[Z7];
    assign z8 = z_win[Z8];
    assign z9 = z_win[Z9];

endmodule

// File: tb/tb_sobel_window_gen.sv
// Directed bench for sobel_window_gen: a 4x4 and a 6x5 instance share inputs;
// a small raster model predicts every window, in_ready and frame_done.
module tb_sobel_window_gen;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic [7:0] in_pixel = 8'd0;

    always #5 clk = ~clk;

    logic       a_ir, a_ov, a_fd, b_ir, b_ov, b_fd;
    logic [7:0] a_z [9];
    logic [7:0] b_z [9];

    sobel_window_gen #(.IMG_W(4), .IMG_H(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_pixel(in_pixel),
        .in_ready(a_ir), .out_valid(a_ov), .out_ready(out_ready),
        .z1(a_z[0]), .z2(a_z[1]), .z3(a_z[2]), .z4(a_z[3]), .z5(a_z[4]),
        .z6(a_z[5]), .z7(a_z[6]), .z8(a_z[7]), .z9(a_z[8]),
        .frame_done(a_fd)
    );

    sobel_window_gen #(.IMG_W(6), .IMG_H(5)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_pixel(in_pixel),
        .in_ready(b_ir), .out_valid(b_ov), .out_ready(out_ready),
        .z1(b_z[0]), .z2(b_z[1]), .z3(b_z[2]), .z4(b_z[3]), .z5(b_z[4]),
        .z6(b_z[5]), .z7(b_z[6]), .z8(b_z[7]), .z9(b_z[8]),
        .frame_done(b_fd)
    );

    bit          sel65 = 1'b0;
    logic        obs_ir, obs_ov, obs_fd;
    logic [71:0] obs_z;

    always_comb begin
        if (sel65) begin
            obs_ir = b_ir; obs_ov = b_ov; obs_fd = b_fd;
            obs_z  = {b_z[0], b_z[1], b_z[2], b_z[3], b_z[4], b_z[5], b_z[6], b_z[7], b_z[8]};
        end else begin
            obs_ir = a_ir; obs_ov = a_ov; obs_fd = a_fd;
            obs_z  = {a_z[0], a_z[1], a_z[2], a_z[3], a_z[4], a_z[5], a_z[6], a_z[7], a_z[8]};
        end
    end

    localparam logic [71:0] FIRST_A = {8'd0, 8'd1, 8'd2, 8'd10, 8'd11, 8'd12, 8'd20, 8'd21, 8'd22};
    localparam logic [71:0] FIRST_B = {8'd100, 8'd101, 8'd102, 8'd110, 8'd111, 8'd112, 8'd120, 8'd121, 8'd122};

    int          n_assert = 0;
    int          n_fail = 0;
    int          cr, cc, w_cur, h_cur, mode, pbase, next_base;
    int          n_acc, n_fd;
    logic [71:0] q[$];
    logic [71:0] got[$];

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] pix_of(input int r, input int c);
        if (mode == 1) return 8'((r * 37 + c * 11 + 5) % 256);
        return 8'((pbase + 10 * r + c) % 256);
    endfunction

    function automatic logic [71:0] win_of(input int r, input int c);
        logic [71:0] w = '0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                w = {w[63:0], pix_of(r - 2 + i, c - 2 + j)};
        return w;
    endfunction

    // Called just after a falling edge; ends just after the next falling edge.
    task automatic step(input logic iv, input logic ordy);
        logic acc;
        logic fd_exp;
        in_valid  = iv;
        out_ready = ordy;
        in_pixel  = pix_of(cr, cc);
        #1;
        chk("in_ready", {71'd0, obs_ir}, {71'd0, (q.size() == 0) || ordy});
        acc = iv && ((q.size() == 0) || ordy);
        if (ordy && q.size() > 0) begin
            got.push_back(obs_z);
            void'(q.pop_front());
        end
        fd_exp = 1'b0;
        if (acc) begin
            n_acc++;
            if (cr >= 2 && cc >= 2) q.push_back(win_of(cr, cc));
            if (cc == w_cur - 1) begin
                cc = 0;
                if (cr == h_cur - 1) begin
                    cr = 0;
                    fd_exp = 1'b1;
                    pbase = next_base;
                end else begin
                    cr++;
                end
            end else begin
                cc++;
            end
        end
        @(posedge clk);
        @(negedge clk);
        chk("out_valid", {71'd0, obs_ov}, {71'd0, q.size() > 0});
        if (q.size() > 0) chk("window", obs_z, q[0]);
        chk("frame_done", {71'd0, obs_fd}, {71'd0, fd_exp});
        if (obs_fd) n_fd++;
    endtask

    task automatic do_reset();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        rst_n     = 1'b0;
        #1;
        chk("rst_out_valid", {71'd0, obs_ov}, 72'd0);
        chk("rst_z", obs_z, 72'd0);
        chk("rst_in_ready", {71'd0, obs_ir}, 72'd1);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_frame_done", {71'd0, obs_fd}, 72'd0);
        @(negedge clk);
        rst_n = 1'b1;
        q.delete();
        got.delete();
        cr = 0; cc = 0; n_acc = 0; n_fd = 0;
    endtask

    task automatic check_4x4(input string pfx);
        chk({pfx, "_count"}, 72'(got.size()), 72'd4);
        if (got.size() == 4) begin
            chk({pfx, "_first"}, got[0], FIRST_A);
            chk({pfx, "_c0"}, {64'd0, got[0][39:32]}, 72'd11);
            chk({pfx, "_c1"}, {64'd0, got[1][39:32]}, 72'd12);
            chk({pfx, "_c2"}, {64'd0, got[2][39:32]}, 72'd21);
            chk({pfx, "_c3"}, {64'd0, got[3][39:32]}, 72'd22);
        end
        chk({pfx, "_fd_pulses"}, 72'(n_fd), 72'd1);
    endtask

    task automatic run_4x4_full(input string pfx);
        int guard = 0;
        while (n_acc < 16 && guard < 40) begin step(1'b1, 1'b1); guard++; end
        repeat (4) step(1'b0, 1'b1);
        check_4x4(pfx);
    endtask

    initial begin
        int guard;
        logic seen;
        sel65 = 1'b0; mode = 0; pbase = 0; next_base = 0;
        w_cur = 4; h_cur = 4;

        // Scenario 1: continuous 4x4 frame
        do_reset();
        run_4x4_full("s1");

        // Scenario 2: downstream stall on the first window
        do_reset();
        guard = 0;
        while (q.size() == 0 && guard < 20) begin step(1'b1, 1'b1); guard++; end
        chk("s2_first_seen", {71'd0, obs_ov}, 72'd1);
        for (int k = 0; k < 10; k++) begin
            step(1'b1, 1'b0);
            chk("s2_stall_z", obs_z, FIRST_A);
            chk("s2_stall_ready", {71'd0, obs_ir}, 72'd0);
        end
        run_4x4_full("s2");

        // Scenario 3: two back-to-back frames
        do_reset();
        next_base = 100;
        guard = 0;
        while (n_acc < 32 && guard < 80) begin step(1'b1, 1'b1); guard++; end
        repeat (4) step(1'b0, 1'b1);
        chk("s3_count", 72'(got.size()), 72'd8);
        if (got.size() == 8) chk("s3_second_first", got[4], FIRST_B);
        chk("s3_fd_pulses", 72'(n_fd), 72'd2);
        pbase = 0; next_base = 0;

        // Scenario 4: 6x5 image with random gaps and backpressure
        sel65 = 1'b1; mode = 1; w_cur = 6; h_cur = 5;
        do_reset();
        guard = 0;
        while (n_acc < 30 && guard < 600) begin
            step($urandom_range(0, 9) >= 3, $urandom_range(0, 3) != 0);
            guard++;
        end
        chk("s4_all_accepted", 72'(n_acc), 72'd30);
        repeat (4) step(1'b0, 1'b1);
        chk("s4_count", 72'(got.size()), 72'd12);
        chk("s4_fd_pulses", 72'(n_fd), 72'd1);

        // Scenario 5: reset after 7 pixels, then a clean frame
        sel65 = 1'b0; mode = 0; w_cur = 4; h_cur = 4;
        do_reset();
        repeat (7) step(1'b1, 1'b1);
        chk("s5_pre_reset_acc", 72'(n_acc), 72'd7);
        do_reset();
        chk("s5_post_out_valid", {71'd0, obs_ov}, 72'd0);
        chk("s5_post_z", obs_z, 72'd0);
        run_4x4_full("s5");

        seen = (n_fail == 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        if (!seen) $display("see FAIL lines above");
        $finish;
    end

endmodule
